// File: rtl/ip_rx_parser.sv
// IPv4 receive parser: validates the header, strips header and Ethernet padding, forwards payload.
// Define IP_RX_CSUM_CHK_EN to also require a correct header checksum.
module ip_rx_parser #(
  parameter logic [31:0] LOCAL_IP     = 32'hC0A8_0102,
  parameter bit          ACCEPT_BCAST = 1'b1,
  parameter int          MAX_IP_LEN   = 1500
) (
  input  logic        rx_mac_aclk,
  input  logic        rx_mac_resetn,
  input  logic [7:0]  rx_axis_mac_tdata,
  input  logic        rx_axis_mac_tvalid,
  input  logic        rx_axis_mac_tlast,
  input  logic        rx_axis_mac_tuser,
  output logic [7:0]  rx_axis_ip_tdata,
  output logic        rx_axis_ip_tvalid,
  output logic        rx_axis_ip_tlast,
  output logic [1:0]  rx_axis_ip_tuser,
  output logic        rx_axis_ip_tdest,
  output logic [31:0] rx_ip_src_addr,
  output logic        rx_ip_drop
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HDR     = 3'd1;
  localparam logic [2:0] ST_VERDICT = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_PAD     = 3'd4;
  localparam logic [2:0] ST_DROP    = 3'd5;
  localparam logic [15:0] MAX_LEN_C = 16'(MAX_IP_LEN);

  logic [2:0]  state_r;
  logic [10:0] byte_cnt_r;
  logic [7:0]  ver_ihl_r;
  logic [15:0] tot_len_r;
  logic [13:0] frag_r;
  logic [7:0]  proto_r;
  logic [31:0] src_cap_r;
  logic [31:0] dst_r;
  logic [7:0]  hold_r;
  logic        hold_vld_r;
  logic        flush_r;
  logic        flush_err_r;
  logic        flush_mac_r;
  logic [7:0]  tdata_r;
  logic        tvalid_r;
  logic        tlast_r;
  logic [1:0]  tuser_r;
  logic        tdest_r;
  logic [31:0] src_out_r;
  logic        drop_r;

  logic        beat_s;
  logic        hdr_phase_s;
  logic [3:0]  ihl_s;
  logic [10:0] hdr_len_s;
  logic [10:0] hdr_last_s;
  logic [10:0] last_idx_s;
  logic        dest_ok_s;
  logic        csum_ok_s;
  logic        verdict_ok_s;

  assign beat_s      = rx_axis_mac_tvalid;
  assign hdr_phase_s = beat_s && ((state_r == ST_IDLE) || (state_r == ST_HDR));
  assign ihl_s       = ver_ihl_r[3:0];
  assign hdr_len_s   = {5'd0, ihl_s, 2'b00};
  // A too-short IHL still reads a full 20-byte header so every field is seen before the verdict.
  assign hdr_last_s  = (ihl_s < 4'd5) ? 11'd19 : (hdr_len_s - 11'd1);
  assign last_idx_s  = tot_len_r[10:0] - 11'd1;
  assign dest_ok_s   = (dst_r == LOCAL_IP) || (ACCEPT_BCAST && (dst_r == 32'hFFFF_FFFF));
  assign verdict_ok_s = (ver_ihl_r[7:4] == 4'd4) && (ihl_s >= 4'd5) &&
                        (tot_len_r >= {5'd0, hdr_len_s}) && (tot_len_r <= MAX_LEN_C) &&
                        (frag_r == 14'd0) && ((proto_r == 8'd1) || (proto_r == 8'd17)) &&
                        dest_ok_s && csum_ok_s;

`ifdef IP_RX_CSUM_CHK_EN
  logic [19:0] csum_acc_r;
  logic [16:0] fold1_s;
  logic [15:0] fold2_s;

  assign fold1_s   = {1'b0, csum_acc_r[15:0]} + {13'd0, csum_acc_r[19:16]};
  assign fold2_s   = fold1_s[15:0] + {15'd0, fold1_s[16]};
  assign csum_ok_s = (fold2_s == 16'hFFFF);

  // Header checksum accumulation: even byte index is the high byte of each word.
  always_ff @(posedge rx_mac_aclk or negedge rx_mac_resetn) begin
    if (!rx_mac_resetn) begin
      csum_acc_r <= 20'd0;
    end else if (hdr_phase_s) begin
      if (state_r == ST_IDLE) begin
        csum_acc_r <= {4'd0, rx_axis_mac_tdata, 8'h00};
      end else if (byte_cnt_r[0]) begin
        csum_acc_r <= csum_acc_r + {12'd0, rx_axis_mac_tdata};
      end else begin
        csum_acc_r <= csum_acc_r + {4'd0, rx_axis_mac_tdata, 8'h00};
      end
    end
  end
`else
  assign csum_ok_s = 1'b1;
`endif

  // Beat counter: index of the current byte within the Ethernet payload.
  always_ff @(posedge rx_mac_aclk or negedge rx_mac_resetn) begin
    if (!rx_mac_resetn) begin
      byte_cnt_r <= 11'd0;
    end else if (beat_s) begin
      byte_cnt_r <= rx_axis_mac_tlast ? 11'd0 : (byte_cnt_r + 11'd1);
    end
  end

  // Header field capture.
  always_ff @(posedge rx_mac_aclk or negedge rx_mac_resetn) begin
    if (!rx_mac_resetn) begin
      ver_ihl_r <= 8'd0;
      tot_len_r <= 16'd0;
      frag_r    <= 14'd0;
      proto_r   <= 8'd0;
      src_cap_r <= 32'd0;
      dst_r     <= 32'd0;
    end else if (hdr_phase_s) begin
      case (byte_cnt_r)
        11'd0:  ver_ihl_r        <= rx_axis_mac_tdata;
        11'd2:  tot_len_r[15:8]  <= rx_axis_mac_tdata;
        11'd3:  tot_len_r[7:0]   <= rx_axis_mac_tdata;
        11'd6:  frag_r[13:8]     <= rx_axis_mac_tdata[5:0];
        11'd7:  frag_r[7:0]      <= rx_axis_mac_tdata;
        11'd9:  proto_r          <= rx_axis_mac_tdata;
        11'd12, 11'd13, 11'd14, 11'd15: src_cap_r <= {src_cap_r[23:0], rx_axis_mac_tdata};
        11'd16, 11'd17, 11'd18, 11'd19: dst_r     <= {dst_r[23:0], rx_axis_mac_tdata};
        default: ;
      endcase
    end
  end

  // Frame FSM, one-byte hold register and registered output stage.
  always_ff @(posedge rx_mac_aclk or negedge rx_mac_resetn) begin
    if (!rx_mac_resetn) begin
      state_r     <= ST_IDLE;
      hold_r      <= 8'd0;
      hold_vld_r  <= 1'b0;
      flush_r     <= 1'b0;
      flush_err_r <= 1'b0;
      flush_mac_r <= 1'b0;
      tdata_r     <= 8'd0;
      tvalid_r    <= 1'b0;
      tlast_r     <= 1'b0;
      tuser_r     <= 2'b00;
      tdest_r     <= 1'b0;
      src_out_r   <= 32'd0;
      drop_r      <= 1'b0;
    end else begin
      tvalid_r <= 1'b0;
      tlast_r  <= 1'b0;
      tuser_r  <= 2'b00;
      drop_r   <= 1'b0;
      flush_r  <= 1'b0;
      // The tlast beat carried payload: its byte goes out one cycle after the previous one.
      if (flush_r) begin
        tvalid_r   <= 1'b1;
        tdata_r    <= hold_r;
        tlast_r    <= 1'b1;
        tuser_r    <= {flush_err_r, flush_mac_r};
        hold_vld_r <= 1'b0;
      end
      if (beat_s) begin
        case (state_r)
          ST_IDLE: begin
            if (rx_axis_mac_tlast) begin
              drop_r <= 1'b1;
            end else begin
              state_r <= ST_HDR;
            end
          end
          ST_HDR: begin
            if (rx_axis_mac_tlast) begin
              drop_r  <= 1'b1;
              state_r <= ST_IDLE;
            end else if (byte_cnt_r == hdr_last_s) begin
              state_r <= ST_VERDICT;
            end
          end
          ST_VERDICT: begin
            if (rx_axis_mac_tlast) begin
              drop_r  <= 1'b1;
              state_r <= ST_IDLE;
            end else if (!verdict_ok_s) begin
              drop_r  <= 1'b1;
              state_r <= ST_DROP;
            end else begin
              tdest_r   <= (proto_r == 8'd1);
              src_out_r <= src_cap_r;
              if (tot_len_r == {5'd0, hdr_len_s}) begin
                hold_vld_r <= 1'b0;
                state_r    <= ST_PAD;
              end else begin
                hold_r     <= rx_axis_mac_tdata;
                hold_vld_r <= 1'b1;
                state_r    <= (byte_cnt_r == last_idx_s) ? ST_PAD : ST_PAYLOAD;
              end
            end
          end
          ST_PAYLOAD: begin
            tvalid_r <= 1'b1;
            tdata_r  <= hold_r;
            hold_r   <= rx_axis_mac_tdata;
            if (rx_axis_mac_tlast) begin
              flush_r     <= 1'b1;
              flush_err_r <= (byte_cnt_r != last_idx_s);
              flush_mac_r <= rx_axis_mac_tuser;
              state_r     <= ST_IDLE;
            end else if (byte_cnt_r == last_idx_s) begin
              state_r <= ST_PAD;
            end
          end
          ST_PAD: begin
            if (rx_axis_mac_tlast) begin
              state_r <= ST_IDLE;
              if (hold_vld_r) begin
                tvalid_r   <= 1'b1;
                tdata_r    <= hold_r;
                tlast_r    <= 1'b1;
                tuser_r    <= {1'b0, rx_axis_mac_tuser};
                hold_vld_r <= 1'b0;
              end
            end
          end
          ST_DROP: begin
            if (rx_axis_mac_tlast) begin
              state_r <= ST_IDLE;
            end
          end
          default: state_r <= ST_IDLE;
        endcase
      end
    end
  end

  assign rx_axis_ip_tdata  = tdata_r;
  assign rx_axis_ip_tvalid = tvalid_r;
  assign rx_axis_ip_tlast  = tlast_r;
  assign rx_axis_ip_tuser  = tuser_r;
  assign rx_axis_ip_tdest  = tdest_r;
  assign rx_ip_src_addr    = src_out_r;
  assign rx_ip_drop        = drop_r;

endmodule

// File: tb/tb_ip_rx_parser.sv
// Directed, table-driven bench for ip_rx_parser: builds IPv4 frames and checks the payload stream.
module tb_ip_rx_parser;

  localparam logic [31:0] LOCAL_IP = 32'hC0A8_0102;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_d = 8'h00;
  logic        in_v = 1'b0;
  logic        in_l = 1'b0;
  logic        in_u = 1'b0;
  logic [7:0]  ip_tdata;
  logic        ip_tvalid;
  logic        ip_tlast;
  logic [1:0]  ip_tuser;
  logic        ip_tdest;
  logic [31:0] ip_src;
  logic        ip_drop;

  always #5 clk = ~clk;

  ip_rx_parser dut (
    .rx_mac_aclk        (clk),
    .rx_mac_resetn      (rst_n),
    .rx_axis_mac_tdata  (in_d),
    .rx_axis_mac_tvalid (in_v),
    .rx_axis_mac_tlast  (in_l),
    .rx_axis_mac_tuser  (in_u),
    .rx_axis_ip_tdata   (ip_tdata),
    .rx_axis_ip_tvalid  (ip_tvalid),
    .rx_axis_ip_tlast   (ip_tlast),
    .rx_axis_ip_tuser   (ip_tuser),
    .rx_axis_ip_tdest   (ip_tdest),
    .rx_ip_src_addr     (ip_src),
    .rx_ip_drop         (ip_drop)
  );

  typedef struct {
    logic [3:0]  ver;
    logic [3:0]  ihl;
    logic [15:0] tot;
    int          flen;
    logic [7:0]  proto;
    logic [31:0] dst;
    logic [15:0] frag;
    bit          mac_err;
    bit          corrupt;
    bit          gaps;
    int          exp_n;
    bit          exp_dest;
    logic [1:0]  exp_user;
    int          exp_drop;
  } vec_t;

  vec_t        vecs [0:19];
  logic [7:0]  frm [0:1599];
  time         acc_t [0:1599];
  int          n_pass = 0;
  int          n_tot = 0;

  logic [7:0]  q_d[$];
  bit          q_l[$];
  logic [1:0]  q_u[$];
  bit          q_dest[$];
  logic [31:0] q_src[$];
  time         q_t[$];
  int          drop_cnt = 0;
  time         drop_t = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (ip_tvalid) begin
        q_d.push_back(ip_tdata);
        q_l.push_back(ip_tlast);
        q_u.push_back(ip_tuser);
        q_dest.push_back(ip_tdest);
        q_src.push_back(ip_src);
        q_t.push_back($time);
      end
      if (ip_drop) begin
        drop_cnt = drop_cnt + 1;
        drop_t = $time;
      end
    end
  end

  function automatic logic [7:0] pay(input int k, input int idx);
    return 8'(k * 5 + idx * 11 + 1);
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic clear_mon();
    q_d.delete(); q_l.delete(); q_u.delete(); q_dest.delete(); q_src.delete(); q_t.delete();
    drop_cnt = 0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic l, input logic u, output time t);
    in_d = d; in_v = 1'b1; in_l = l; in_u = u;
    @(posedge clk);
    t = $time;
    #1;
    in_v = 1'b0; in_l = 1'b0; in_u = 1'b0; in_d = 8'h00;
  endtask

  task automatic build(input vec_t v, input int idx);
    int          hb;
    logic [31:0] sum;
    logic [31:0] src;
    logic [15:0] cs;
    hb  = (v.ihl < 4'd5) ? 20 : 4 * int'(v.ihl);
    src = 32'h0A00_0100 + 32'(idx);
    for (int i = 0; i < 1600; i++) frm[i] = 8'hEE;
    frm[0] = {v.ver, v.ihl};  frm[1] = 8'h00;
    frm[2] = v.tot[15:8];     frm[3] = v.tot[7:0];
    frm[4] = 8'h12;           frm[5] = 8'h34;
    frm[6] = v.frag[15:8];    frm[7] = v.frag[7:0];
    frm[8] = 8'h40;           frm[9] = v.proto;
    frm[10] = 8'h00;          frm[11] = 8'h00;
    for (int i = 0; i < 4; i++) frm[12 + i] = src[31 - 8 * i -: 8];
    for (int i = 0; i < 4; i++) frm[16 + i] = v.dst[31 - 8 * i -: 8];
    for (int i = 20; i < hb; i++) frm[i] = 8'(i + 1);
    for (int i = hb; i < int'(v.tot); i++) frm[i] = pay(i - hb, idx);
    sum = 32'd0;
    for (int i = 0; i < hb; i += 2) sum = sum + {16'd0, frm[i], frm[i + 1]};
    sum = {16'd0, sum[15:0]} + {16'd0, sum[31:16]};
    sum = {16'd0, sum[15:0]} + {16'd0, sum[31:16]};
    cs = ~sum[15:0];
    frm[10] = cs[15:8];
    frm[11] = cs[7:0];
    if (v.corrupt) frm[10] = frm[10] ^ 8'h5A;
  endtask

  task automatic send(input vec_t v);
    for (int i = 0; i < v.flen; i++) begin
      beat(frm[i], (i == v.flen - 1), v.mac_err && (i == v.flen - 1), acc_t[i]);
      if (v.gaps) repeat ($urandom_range(0, 2)) idle();
    end
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    int          errs;
    int          lasts;
    int          n;
    logic [31:0] exp_src;
    exp_src = 32'h0A00_0100 + 32'(idx);
    n = q_d.size();
    chk($sformatf("v%0d count", idx), n, v.exp_n);
    errs = 0;
    for (int k = 0; k < n; k++) if (q_d[k] != pay(k, idx)) errs++;
    chk($sformatf("v%0d data_errs", idx), errs, 0);
    lasts = 0;
    for (int k = 0; k < n; k++) if (q_l[k]) lasts++;
    chk($sformatf("v%0d tlast_cnt", idx), lasts, (v.exp_n > 0) ? 1 : 0);
    if (n > 0) begin
      chk($sformatf("v%0d tlast_pos", idx), q_l[n - 1], 1);
      chk($sformatf("v%0d tuser", idx), q_u[n - 1], v.exp_user);
      errs = 0;
      for (int k = 0; k < n; k++) if ((q_dest[k] != v.exp_dest) || (q_src[k] != exp_src)) errs++;
      chk($sformatf("v%0d dest_src_errs", idx), errs, 0);
    end
    chk($sformatf("v%0d drops", idx), drop_cnt, v.exp_drop);
  endtask

  initial begin
    int errs;
    int lasts;
    //           ver   ihl   tot      flen  proto  dst            frag      mac   cor   gap   n     dest  user   drop
    vecs[0]  = '{4'd4, 4'd5, 16'd60,  60,   8'd1,  LOCAL_IP,      16'h0000, 1'b0, 1'b0, 1'b0, 40,   1'b1, 2'b00, 0};
    vecs[1]  = '{4'd4, 4'd5, 16'd28,  46,   8'd17, LOCAL_IP,      16'h0000, 1'b1, 1'b0, 1'b0, 8,    1'b0, 2'b01, 0};
    vecs[2]  = '{4'd4, 4'd6, 16'd40,  46,   8'd17, LOCAL_IP,      16'h0000, 1'b0, 1'b0, 1'b0, 16,   1'b0, 2'b00, 0};
`ifdef IP_RX_CSUM_CHK_EN
    vecs[3]  = '{4'd4, 4'd5, 16'd60,  60,   8'd1,  LOCAL_IP,      16'h0000, 1'b0, 1'b1, 1'b0, 0,    1'b1, 2'b00, 1};
`else
    vecs[3]  = '{4'd4, 4'd5, 16'd60,  60,   8'd1,  LOCAL_IP,      16'h0000, 1'b0, 1'b1, 1'b0, 40,   1'b1, 2'b00, 0};
`endif
    vecs[4]  = '{4'd4, 4'd5, 16'd60,  60,   8'd1,  32'hC0A80109,  16'h0000, 1'b0, 1'b0, 1'b0, 0,    1'b0, 2'b00, 1};
    vecs[5]  = '{4'd4, 4'd5, 16'd60,  60,   8'd6,  LOCAL_IP,      16'h0000, 1'b0, 1'b0, 1'b0, 0,    1'b0, 2'b00, 1};
    vecs[6]  = '{4'd4, 4'd5, 16'd60,  60,   8'd17, LOCAL_IP,      16'h2000, 1'b0, 1'b0, 1'b0, 0,    1'b0, 2'b00, 1};
    vecs[7]  = '{4'd4, 4'd5, 16'd100, 50,   8'd17, LOCAL_IP,      16'h0000, 1'b1, 1'b0, 1'b0, 30,   1'b0, 2'b11, 0};
    vecs[8]  = '{4'd4, 4'd5, 16'd60,  60,   8'd1,  LOCAL_IP,      16'h0000, 1'b0, 1'b0, 1'b1, 40,   1'b1, 2'b00, 0};
    vecs[9]  = '{4'd4, 4'd5, 16'd30,  46,   8'd17, 32'hFFFFFFFF,  16'h0000, 1'b0, 1'b0, 1'b0, 10,   1'b0, 2'b00, 0};
    vecs[10] = '{4'd4, 4'd5, 16'd60,  60,   8'd17, LOCAL_IP,      16'h0001, 1'b0, 1'b0, 1'b0, 0,    1'b0, 2'b00, 1};
    vecs[11] = '{4'd4, 4'd5, 16'd1501, 60,  8'd17, LOCAL_IP,      16'h0000, 1'b0, 1'b0, 1'b0, 0,    1'b0, 2'b00, 1};
    vecs[12] = '{4'd4, 4'd5, 16'd20,  46,   8'd17, LOCAL_IP,      16'h0000, 1'b0, 1'b0, 1'b0, 0,    1'b0, 2'b00, 0};
    vecs[13] = '{4'd6, 4'd5, 16'd60,  60,   8'd17, LOCAL_IP,      16'h0000, 1'b0, 1'b0, 1'b0, 0,    1'b0, 2'b00, 1};
    vecs[14] = '{4'd4, 4'd5, 16'd60,  10,   8'd17, LOCAL_IP,      16'h0000, 1'b0, 1'b0, 1'b0, 0,    1'b0, 2'b00, 1};
    vecs[15] = '{4'd4, 4'd5, 16'd16,  46,   8'd17, LOCAL_IP,      16'h0000, 1'b0, 1'b0, 1'b0, 0,    1'b0, 2'b00, 1};
    vecs[16] = '{4'd4, 4'd5, 16'd21,  46,   8'd17, LOCAL_IP,      16'h0000, 1'b0, 1'b0, 1'b0, 1,    1'b0, 2'b00, 0};
    vecs[17] = '{4'd4, 4'd5, 16'd28,  46,   8'd17, LOCAL_IP,      16'h4000, 1'b0, 1'b0, 1'b0, 8,    1'b0, 2'b00, 0};
    vecs[18] = '{4'd4, 4'd4, 16'd60,  60,   8'd17, LOCAL_IP,      16'h0000, 1'b0, 1'b0, 1'b0, 0,    1'b0, 2'b00, 1};
    vecs[19] = '{4'd4, 4'd5, 16'd1500, 1500, 8'd17, LOCAL_IP,     16'h0000, 1'b0, 1'b0, 1'b0, 1480, 1'b0, 2'b00, 0};

    // reset state
    #12;
    chk("rst tvalid", ip_tvalid, 0);
    chk("rst tlast", ip_tlast, 0);
    chk("rst tuser", ip_tuser, 0);
    chk("rst tdest", ip_tdest, 0);
    chk("rst src", ip_src, 0);
    chk("rst drop", ip_drop, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    for (int n = 0; n < 20; n++) begin
      clear_mon();
      build(vecs[n], n);
      send(vecs[n]);
      repeat (4) idle();
      check_vec(n, vecs[n]);
    end

    // output timing relative to input beats (UDP padded frame)
    clear_mon();
    build(vecs[1], 1);
    send(vecs[1]);
    repeat (4) idle();
    chk("timing count", q_t.size(), 8);
    if (q_t.size() == 8) begin
      chk("first byte time", longint'(q_t[0]), longint'(acc_t[21] + 5));
      chk("tlast time", longint'(q_t[7]), longint'(acc_t[45] + 5));
    end

    // drop pulse timing: verdict failure and tlast inside header
    clear_mon();
    build(vecs[4], 4);
    send(vecs[4]);
    repeat (4) idle();
    chk("verdict drop time", longint'(drop_t), longint'(acc_t[20] + 5));
    clear_mon();
    build(vecs[14], 14);
    send(vecs[14]);
    repeat (4) idle();
    chk("hdr tlast drop time", longint'(drop_t), longint'(acc_t[9] + 5));

    // back-to-back frames with no idle between them
    clear_mon();
    build(vecs[0], 0);
    send(vecs[0]);
    build(vecs[1], 1);
    send(vecs[1]);
    repeat (4) idle();
    chk("b2b count", q_d.size(), 48);
    errs = 0;
    lasts = 0;
    for (int k = 0; k < q_d.size(); k++) begin
      if (q_d[k] != ((k < 40) ? pay(k, 0) : pay(k - 40, 1))) errs++;
      if (q_l[k]) lasts++;
    end
    chk("b2b data_errs", errs, 0);
    chk("b2b tlast_cnt", lasts, 2);

    // reset in the middle of the payload, then a normal frame
    clear_mon();
    build(vecs[0], 0);
    for (int i = 0; i < 31; i++) beat(frm[i], 1'b0, 1'b0, acc_t[i]);
    chk("pre-reset tvalid", ip_tvalid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid-reset tvalid", ip_tvalid, 0);
    chk("mid-reset tdest", ip_tdest, 0);
    chk("mid-reset src", ip_src, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    clear_mon();
    build(vecs[1], 1);
    send(vecs[1]);
    repeat (4) idle();
    check_vec(1, vecs[1]);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
